// File: rtl/jtag_idcode_reader.sv
// jtag_idcode_reader
// Host-side JTAG sequencer that drives a TAP through Test-Logic-Reset to
// Shift-DR, shifts the selected DR out LSB first while sampling tdo, parks
// the TAP back in Run-Test/Idle and presents the captured word with a
// one-cycle done pulse.
//
// Optional feature macro: JTAG_IDCODE_READER_CHECK_EN
//   defined   -> idcode_match is registered against EXPECTED_IDCODE when
//                the sequence enters DONE.
//   undefined -> no comparator; idcode_match is tied to 0.
//
// Sampling note: the TAP only reaches Shift-DR one cycle after our CAP_DR
// state (it passes through Capture-DR during our first SHIFT cycle), so the
// first SHIFT cycle is skipped and the final sample is taken at the end of
// EXIT1, which still yields exactly DR_WIDTH samples.
module jtag_idcode_reader #(
  parameter int          DR_WIDTH        = 32,
  parameter int          RESET_CYCLES    = 5,
  parameter logic [31:0] EXPECTED_IDCODE = 32'h000FAF01
) (
  input  logic                clk_tck,
  input  logic                reset,
  input  logic                start,
  input  logic                tdo,
  output logic                tms,
  output logic                tdi,
  output logic                trst_n,
  output logic                tap_enable,
  output logic                busy,
  output logic                done,
  output logic [DR_WIDTH-1:0] idcode,
  output logic                idcode_match
);

  localparam int CNT_MAX = (DR_WIDTH > RESET_CYCLES) ? DR_WIDTH : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] TLR_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DR_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE,
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SHIFT,
    EXIT1,
    UPDATE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tms_nxt;
  logic             accept;
  logic             sample;

  // IDCODE reads never load data into the DR
  assign tdi = 1'b0;

  // Next-state, per-state counter and the TMS level for the upcoming state
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cnt_nxt   = '0;
    tms_nxt   = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = TLR;
          accept    = 1'b1;
        end
      end
      TLR:     if (cnt == TLR_LAST) state_nxt = RTI;
      RTI:     state_nxt = SEL_DR;
      SEL_DR:  state_nxt = CAP_DR;
      CAP_DR:  state_nxt = SHIFT;
      SHIFT:   if (cnt == SHIFT_LAST) state_nxt = EXIT1;
      EXIT1:   state_nxt = UPDATE;
      UPDATE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if ((state_nxt == state) && (state != IDLE) && (state != DONE)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end

    case (state_nxt)
      TLR:     tms_nxt = 1'b1;
      RTI:     tms_nxt = 1'b0;
      SEL_DR:  tms_nxt = 1'b1;
      CAP_DR:  tms_nxt = 1'b0;
      SHIFT:   tms_nxt = (cnt_nxt == SHIFT_LAST);
      EXIT1:   tms_nxt = 1'b1;
      UPDATE:  tms_nxt = 1'b0;
      default: tms_nxt = 1'b1;
    endcase
  end

  // tdo carries a valid DR bit from SHIFT cycle 2 through EXIT1
  assign sample = ((state == SHIFT) && (cnt != '0)) || (state == EXIT1);

  // State register and per-state cycle counter
  always_ff @(posedge clk_tck or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered TAP-facing pins and handshake outputs
  always_ff @(posedge clk_tck or posedge reset) begin
    if (reset) begin
      tms        <= 1'b1;
      trst_n     <= 1'b0;
      tap_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tms  <= tms_nxt;
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      if (accept) begin
        trst_n     <= 1'b1;
        tap_enable <= 1'b1;
      end
    end
  end

  // Capture shift register: new samples enter at the MSB and move right
  always_ff @(posedge clk_tck or posedge reset) begin
    if (reset) begin
      idcode <= '0;
    end else if (accept) begin
      idcode <= '0;
    end else if (sample) begin
      idcode <= {tdo, idcode[DR_WIDTH-1:1]};
    end
  end

`ifdef JTAG_IDCODE_READER_CHECK_EN
  localparam logic [63:0]         EXPECTED_WIDE = 64'(EXPECTED_IDCODE);
  localparam logic [DR_WIDTH-1:0] EXPECTED_DR   = EXPECTED_WIDE[DR_WIDTH-1:0];

  // Compare the completed word as the sequence enters DONE
  always_ff @(posedge clk_tck or posedge reset) begin
    if (reset) begin
      idcode_match <= 1'b0;
    end else if (accept) begin
      idcode_match <= 1'b0;
    end else if (state_nxt == DONE) begin
      idcode_match <= (idcode == EXPECTED_DR);
    end
  end
`else
  logic unused_expected;

  assign unused_expected = ^EXPECTED_IDCODE;
  assign idcode_match    = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// tb_jtag_idcode_reader
// Drives jtag_idcode_reader into a behavioural IEEE 1149.1 TAP model whose
// DR is loaded with a chosen word at Capture-DR. A scoreboard holds the
// expected word and start time of every accepted request; a monitor checks
// each done pulse against it.
module tb_jtag_idcode_reader;

  localparam int          DR_WIDTH        = 32;
  localparam int          RESET_CYCLES    = 5;
  localparam logic [31:0] EXPECTED_IDCODE = 32'h000FAF01;
  localparam int          SEQ_LEN         = RESET_CYCLES + DR_WIDTH + 6;

  logic                clk_tck;
  logic                reset;
  logic                start;
  logic                tdo;
  logic                tms;
  logic                tdi;
  logic                trst_n;
  logic                tap_enable;
  logic                busy;
  logic                done;
  logic [DR_WIDTH-1:0] idcode;
  logic                idcode_match;

  jtag_idcode_reader #(
    .DR_WIDTH       (DR_WIDTH),
    .RESET_CYCLES   (RESET_CYCLES),
    .EXPECTED_IDCODE(EXPECTED_IDCODE)
  ) dut (
    .clk_tck     (clk_tck),
    .reset       (reset),
    .start       (start),
    .tdo         (tdo),
    .tms         (tms),
    .tdi         (tdi),
    .trst_n      (trst_n),
    .tap_enable  (tap_enable),
    .busy        (busy),
    .done        (done),
    .idcode      (idcode),
    .idcode_match(idcode_match)
  );

  initial begin
    clk_tck = 1'b0;
    forever #5 clk_tck = ~clk_tck;
  end

  typedef enum int {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SHIFT_DR, T_EXIT1_DR, T_PAUSE_DR,
    T_EXIT2_DR, T_UPD_DR, T_SEL_IR, T_CAP_IR, T_SHIFT_IR, T_EXIT1_IR,
    T_PAUSE_IR, T_EXIT2_IR, T_UPD_IR
  } tap_t;

  tap_t                tap_state = T_RTI;
  logic [DR_WIDTH-1:0] tap_dr    = '0;
  logic [DR_WIDTH-1:0] tap_word  = '0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:      return m ? T_TLR      : T_RTI;
      T_RTI:      return m ? T_SEL_DR   : T_RTI;
      T_SEL_DR:   return m ? T_SEL_IR   : T_CAP_DR;
      T_CAP_DR:   return m ? T_EXIT1_DR : T_SHIFT_DR;
      T_SHIFT_DR: return m ? T_EXIT1_DR : T_SHIFT_DR;
      T_EXIT1_DR: return m ? T_UPD_DR   : T_PAUSE_DR;
      T_PAUSE_DR: return m ? T_EXIT2_DR : T_PAUSE_DR;
      T_EXIT2_DR: return m ? T_UPD_DR   : T_SHIFT_DR;
      T_UPD_DR:   return m ? T_SEL_DR   : T_RTI;
      T_SEL_IR:   return m ? T_TLR      : T_CAP_IR;
      T_CAP_IR:   return m ? T_EXIT1_IR : T_SHIFT_IR;
      T_SHIFT_IR: return m ? T_EXIT1_IR : T_SHIFT_IR;
      T_EXIT1_IR: return m ? T_UPD_IR   : T_PAUSE_IR;
      T_PAUSE_IR: return m ? T_EXIT2_IR : T_PAUSE_IR;
      T_EXIT2_IR: return m ? T_UPD_IR   : T_SHIFT_IR;
      default:    return m ? T_SEL_DR   : T_RTI;
    endcase
  endfunction

  // Behavioural TAP: loads tap_word at Capture-DR and shifts LSB first
  always @(posedge clk_tck or negedge trst_n) begin
    if (!trst_n) begin
      tap_state <= T_TLR;
    end else begin
      if (tap_state == T_CAP_DR) tap_dr <= tap_word;
      else if (tap_state == T_SHIFT_DR) tap_dr <= {tdi, tap_dr[DR_WIDTH-1:1]};
      tap_state <= tap_next(tap_state, tms);
    end
  end

  assign tdo = tap_dr[0];

  typedef struct {
    logic [DR_WIDTH-1:0] word;
    int                  start_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   errors     = 0;
  int   edge_count = 0;
  int   done_count = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  function automatic logic expected_match(input logic [DR_WIDTH-1:0] w);
`ifdef JTAG_IDCODE_READER_CHECK_EN
    return (w == EXPECTED_IDCODE[DR_WIDTH-1:0]);
`else
    return 1'b0;
`endif
  endfunction

  // Edge counter used to time done relative to the accepting edge
  always @(posedge clk_tck) edge_count <= edge_count + 1;

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk_tck) begin
    if (!reset && done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        check_output("unexpected done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_output("idcode", idcode, mon_e.word);
        check_output("idcode_match", idcode_match, expected_match(mon_e.word));
        check_output("done cycle", edge_count - mon_e.start_edge + 1, SEQ_LEN);
        check_output("busy at done", busy, 1);
        check_output("tap parked in rti", tap_state == T_RTI, 1);
      end
    end
  end

  // Issue an accepted start at the current negedge; returns just after edge 0
  task automatic apply_stimulus(input logic [DR_WIDTH-1:0] word);
    exp_t e;
    tap_word = word;
    start    = 1'b1;
    @(posedge clk_tck);
    #1;
    start        = 1'b0;
    e.word       = word;
    e.start_edge = edge_count;
    sb_q.push_back(e);
  endtask

  // A start pulse the DUT is expected to ignore
  task automatic pulse_ignored_start();
    start = 1'b1;
    @(posedge clk_tck);
    #1;
    start = 1'b0;
  endtask

  // Wait for the scoreboard to drain, bounded by a cycle budget
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk_tck);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check_output("done timeout", 0, 1);
      sb_q.delete();
    end
  endtask

  initial begin
    int                  mism;
    logic                exp_tms;
    logic [DR_WIDTH-1:0] w;
    exp_t                e;

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk_tck);
    check_output("reset tms", tms, 1);
    check_output("reset tdi", tdi, 0);
    check_output("reset trst_n", trst_n, 0);
    check_output("reset tap_enable", tap_enable, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset idcode", idcode, 0);
    check_output("reset idcode_match", idcode_match, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_tck);
    check_output("idle trst_n held low", trst_n, 0);
    check_output("idle tms level", tms, 1);

    $display("[TB] first read with TMS sequence check");
    apply_stimulus(32'h000FAF01);
    mism = 0;
    for (int c = 1; c < SEQ_LEN; c++) begin
      @(negedge clk_tck);
      if (c <= RESET_CYCLES) exp_tms = 1'b1;
      else if (c == RESET_CYCLES + 1) exp_tms = 1'b0;
      else if (c == RESET_CYCLES + 2) exp_tms = 1'b1;
      else if (c == RESET_CYCLES + 3) exp_tms = 1'b0;
      else if (c < RESET_CYCLES + 3 + DR_WIDTH) exp_tms = 1'b0;
      else if (c == RESET_CYCLES + 3 + DR_WIDTH) exp_tms = 1'b1;
      else if (c == RESET_CYCLES + 4 + DR_WIDTH) exp_tms = 1'b1;
      else exp_tms = 1'b0;
      if (tms !== exp_tms) mism++;
      if (c == 1) begin
        check_output("busy cycle 1", busy, 1);
        check_output("trst_n after start", trst_n, 1);
        check_output("tap_enable after start", tap_enable, 1);
        check_output("tdi constant", tdi, 0);
      end
    end
    check_output("tms sequence mismatches", mism, 0);
    wait_idle(SEQ_LEN + 10);

    $display("[TB] pattern A5A5F00F");
    @(negedge clk_tck);
    apply_stimulus(32'hA5A5F00F);
    @(negedge clk_tck);
    check_output("idcode cleared on start", idcode, 0);
    wait_idle(SEQ_LEN + 10);

    $display("[TB] ignored starts in cycles 3 and 20");
    @(negedge clk_tck);
    apply_stimulus($urandom);
    repeat (3) @(negedge clk_tck);
    pulse_ignored_start();
    repeat (17) @(negedge clk_tck);
    pulse_ignored_start();
    wait_idle(SEQ_LEN + 10);
    repeat (4) @(negedge clk_tck);
    check_output("busy after single done", busy, 0);

    $display("[TB] reset in cycle 20");
    apply_stimulus(32'hFFFFFFFF);
    repeat (20) @(negedge clk_tck);
    reset = 1'b1;
    #1;
    sb_q.delete();
    check_output("mid reset busy", busy, 0);
    check_output("mid reset tms", tms, 1);
    check_output("mid reset trst_n", trst_n, 0);
    check_output("mid reset tap_enable", tap_enable, 0);
    check_output("mid reset idcode", idcode, 0);
    @(negedge clk_tck);
    reset = 1'b0;
    @(negedge clk_tck);
    apply_stimulus(32'h3C3C1234);
    wait_idle(SEQ_LEN + 10);

    $display("[TB] back-to-back with start during DONE");
    @(negedge clk_tck);
    apply_stimulus(32'h0F0F5A5A);
    wait_idle(SEQ_LEN + 10);
    w        = 32'hC0DE0001;
    tap_word = w;
    start    = 1'b1;
    @(posedge clk_tck);
    #1;
    @(posedge clk_tck);
    #1;
    start        = 1'b0;
    e.word       = w;
    e.start_edge = edge_count;
    sb_q.push_back(e);
    @(negedge clk_tck);
    check_output("b2b busy", busy, 1);
    check_output("b2b idcode cleared", idcode, 0);
    wait_idle(SEQ_LEN + 10);

    $display("[TB] random reads");
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk_tck);
      apply_stimulus($urandom);
      wait_idle(SEQ_LEN + 10);
    end

    repeat (5) @(negedge clk_tck);
    check_output("done pulse count", done_count, 12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
